// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4-style burst slave backed by a word-addressed RAM.
// Independent read (AR/R) and write (AW/W/B) engines share one RAM array.
// Only full-word beats with FIXED or INCR bursts are served. Other requests,
// and beats whose address falls beyond the RAM, complete with SLVERR.
module axi_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int MEM_AW          = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [BURST_LEN_WIDTH-1:0] ARLEN,
    input  logic [2:0]                 ARSIZE,
    input  logic [1:0]                 ARBURST,
    output logic                       RVALID,
    output logic [DATA_WIDTH-1:0]      RDATA,
    output logic                       RLAST,
    output logic [1:0]                 RRESP,
    input  logic                       RREADY,
    input  logic [ADDR_WIDTH-1:0]      AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [BURST_LEN_WIDTH-1:0] AWLEN,
    input  logic [2:0]                 AWSIZE,
    input  logic [1:0]                 AWBURST,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [DATA_WIDTH-1:0]      WDATA,
    input  logic                       WLAST,
    output logic                       BVALID,
    output logic [1:0]                 BRESP,
    input  logic                       BREADY
);

    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [1:0]            BURST_FIXED = 2'b00;
    localparam logic [1:0]            BURST_INCR  = 2'b01;
    localparam logic [2:0]            SIZE_WORD   = 3'b010;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(4);

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    // Read engine state
    r_state_t                 r_state_reg;
    logic [ADDR_WIDTH-1:0]    rd_addr_reg;
    logic [BURST_LEN_WIDTH-1:0] rd_len_reg, rd_beat_reg, rd_beat_inc;
    logic [1:0]               rd_burst_reg;
    logic                     rd_unsup_reg;
    logic                     arready_reg, rvalid_reg, rlast_reg;
    logic [1:0]               rresp_reg;
    logic [DATA_WIDTH-1:0]    rdata_reg;

    // Write engine state
    w_state_t                 w_state_reg;
    logic [ADDR_WIDTH-1:0]    wr_addr_reg;
    logic [BURST_LEN_WIDTH-1:0] wr_len_reg, wr_beat_reg, wr_beat_inc;
    logic [1:0]               wr_burst_reg;
    logic                     wr_unsup_reg, wr_err_reg;
    logic                     awready_reg, wready_reg, bvalid_reg;
    logic [1:0]               bresp_reg;

    // The read engine looks up either the AR address (new burst) or the
    // following beat address (advancing burst); both paths share one lookup.
    logic                     ar_unsup, aw_unsup;
    logic [ADDR_WIDTH-1:0]    rd_next_addr, rd_sel_addr, wr_next_addr;
    logic                     rd_sel_unsup, rd_sel_err;
    logic [MEM_AW-1:0]        rd_sel_idx, wr_idx;
    logic                     wr_oor, wr_last_beat, wr_beat_err, ram_we;
    logic                     unused_ok;

    assign ar_unsup     = (ARSIZE != SIZE_WORD) || ((ARBURST != BURST_FIXED) && (ARBURST != BURST_INCR));
    assign aw_unsup     = (AWSIZE != SIZE_WORD) || ((AWBURST != BURST_FIXED) && (AWBURST != BURST_INCR));

    assign rd_next_addr = (rd_burst_reg == BURST_INCR) ? rd_addr_reg + BEAT_BYTES : rd_addr_reg;
    assign rd_sel_addr  = (r_state_reg == R_IDLE) ? ARADDR : rd_next_addr;
    assign rd_sel_unsup = (r_state_reg == R_IDLE) ? ar_unsup : rd_unsup_reg;
    assign rd_sel_err   = rd_sel_unsup || (|rd_sel_addr[ADDR_WIDTH-1:MEM_AW+2]);
    assign rd_sel_idx   = rd_sel_addr[MEM_AW+1:2];
    assign rd_beat_inc  = rd_beat_reg + BURST_LEN_WIDTH'(1);

    assign wr_next_addr = (wr_burst_reg == BURST_INCR) ? wr_addr_reg + BEAT_BYTES : wr_addr_reg;
    assign wr_oor       = |wr_addr_reg[ADDR_WIDTH-1:MEM_AW+2];
    assign wr_idx       = wr_addr_reg[MEM_AW+1:2];
    assign wr_last_beat = (wr_beat_reg == wr_len_reg);
    assign wr_beat_inc  = wr_beat_reg + BURST_LEN_WIDTH'(1);
    // Sticky error including this beat: unsupported, out of range, or WLAST misplaced.
    assign wr_beat_err  = wr_err_reg || wr_unsup_reg || wr_oor || (WLAST != wr_last_beat);
    assign ram_we       = rst_n && (w_state_reg == W_DATA) && WVALID && !wr_unsup_reg && !wr_oor;

    // Byte-lane bits of the address never select anything.
    assign unused_ok    = &{1'b0, rd_sel_addr[1:0], wr_addr_reg[1:0]};

    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RDATA   = rdata_reg;
    assign RLAST   = rlast_reg;
    assign RRESP   = rresp_reg;
    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BRESP   = bresp_reg;

    // Read FSM: accepts AR, then presents one registered RAM word per beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_reg  <= R_IDLE;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rresp_reg    <= RESP_OKAY;
            rdata_reg    <= '0;
            rd_addr_reg  <= '0;
            rd_len_reg   <= '0;
            rd_beat_reg  <= '0;
            rd_burst_reg <= BURST_FIXED;
            rd_unsup_reg <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (!arready_reg) begin
                        arready_reg <= 1'b1;
                    end else if (ARVALID) begin
                        rd_addr_reg  <= ARADDR;
                        rd_len_reg   <= ARLEN;
                        rd_burst_reg <= ARBURST;
                        rd_unsup_reg <= ar_unsup;
                        rd_beat_reg  <= '0;
                        rdata_reg    <= rd_sel_err ? '0 : mem[rd_sel_idx];
                        rresp_reg    <= rd_sel_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_reg    <= (ARLEN == '0);
                        rvalid_reg   <= 1'b1;
                        arready_reg  <= 1'b0;
                        r_state_reg  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            rd_addr_reg <= rd_next_addr;
                            rd_beat_reg <= rd_beat_inc;
                            rdata_reg   <= rd_sel_err ? '0 : mem[rd_sel_idx];
                            rresp_reg   <= rd_sel_err ? RESP_SLVERR : RESP_OKAY;
                            rlast_reg   <= (rd_beat_inc == rd_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Write FSM: accepts AW, consumes len+1 W beats, then holds the B response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_reg  <= W_IDLE;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_addr_reg  <= '0;
            wr_len_reg   <= '0;
            wr_beat_reg  <= '0;
            wr_burst_reg <= BURST_FIXED;
            wr_unsup_reg <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (!awready_reg) begin
                        awready_reg <= 1'b1;
                    end else if (AWVALID) begin
                        wr_addr_reg  <= AWADDR;
                        wr_len_reg   <= AWLEN;
                        wr_burst_reg <= AWBURST;
                        wr_unsup_reg <= aw_unsup;
                        wr_beat_reg  <= '0;
                        wr_err_reg   <= 1'b0;
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b1;
                        w_state_reg  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID) begin
                        wr_addr_reg <= wr_next_addr;
                        wr_beat_reg <= wr_beat_inc;
                        wr_err_reg  <= wr_beat_err;
                        if (wr_last_beat) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= wr_beat_err ? RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // RAM write port; the read port above sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_idx] <= WDATA;
        end
    end

endmodule
